// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus carry flop, LSB first,
// wrapped in a start/busy/done handshake. Outputs are registered one cycle behind the FSM.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic             msb_cin_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic s_bit;
    logic carry_next;

    // The single full-adder cell working on the current LSBs.
    assign s_bit      = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
    assign carry_next = (op_a_reg[0] & op_b_reg[0]) |
                        (carry_reg & (op_a_reg[0] ^ op_b_reg[0]));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            msb_cin_reg <= 1'b0;
            cnt_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            busy <= (state_reg == SHIFT);
            done <= (state_reg == DONE);

            // Result flags are published only once all bits are in, so no partial values leak.
            if (state_reg == DONE) begin
                sum  <= res_reg;
                cout <= carry_reg;
                ovf  <= msb_cin_reg ^ carry_reg;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= SHIFT;
                        op_a_reg    <= a;
                        op_b_reg    <= sub ? ~b : b;
                        carry_reg   <= sub;
                        msb_cin_reg <= 1'b0;
                        cnt_reg     <= '0;
                        res_reg     <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    op_a_reg  <= op_a_reg >> 1;
                    op_b_reg  <= op_b_reg >> 1;
                    carry_reg <= carry_next;
                    res_reg   <= {s_bit, res_reg[WIDTH-1:1]};
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt_reg == CNT_MSB_CIN) begin
                        msb_cin_reg <= carry_next;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases, handshake, random 8-bit ops
// and an exhaustive 4-bit sweep against an arithmetic reference model.
module tb_serial_add_sub;

    logic       clk;
    logic       nrst;

    logic       start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       start4, sub4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int checks;
    int errors;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .nrst(nrst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .nrst(nrst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void ref_model(input int w, input int ia, input int ib, input bit is,
                                      output int rs, output bit rc, output bit rv);
        int m, half, sa, sb, raw, sr;
        m    = 1 << w;
        half = m / 2;
        sa   = (ia >= half) ? ia - m : ia;
        sb   = (ib >= half) ? ib - m : ib;
        raw  = is ? ia - ib : ia + ib;
        rs   = raw & (m - 1);
        rc   = is ? (ia >= ib) : (raw >= m);
        sr   = is ? sa - sb : sa + sb;
        rv   = (sr < -half) || (sr >= half);
    endfunction

    // Issue one operation on the 8-bit DUT; operands are scrambled while it runs.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          output int cyc, output bit to, output int bcnt, output bit ovl);
        @(negedge clk);
        a8 = ta; b8 = tb_v; sub8 = ts; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        cyc = 0; to = 1'b1; bcnt = 0; ovl = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            cyc = i;
            if (busy8) bcnt++;
            if (busy8 && done8) ovl = 1'b1;
            if (done8) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                          output int cyc, output bit to);
        @(negedge clk);
        a4 = ta; b4 = tb_v; sub4 = ts; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        cyc = 0; to = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            cyc = i;
            if (done4) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 8'h00) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy4, done4, sum4, cout4, ovf4);
        end
        nrst = 1'b1;
        $display("reset: outputs checked");
    endtask

    // Directed 8-bit case with fixed expected values and latency checks.
    task automatic test_directed(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                                 input logic ts, input logic [7:0] es, input logic ec,
                                 input logic ev);
        int cyc, bcnt;
        bit to, ovl;
        do_op8(ta, tb_v, ts, cyc, to, bcnt, ovl);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout no done within 20 cycles", name);
            return;
        end
        $display("%s: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b after %0d cycles",
                 name, ta, tb_v, ts, sum8, cout8, ovf8, cyc);
        if ({sum8, cout8, ovf8} !== {es, ec, ev}) begin
            errors++;
            $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum8, cout8, ovf8, es, ec, ev);
        end
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL %s_latency got %0d want 9", name, cyc);
        end
        checks++;
        if (bcnt != 8 || ovl) begin
            errors++;
            $display("FAIL %s_busy got busy_cycles=%0d overlap=%b want 8/0", name, bcnt, ovl);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc, bcnt, extra;
        bit to, ovl;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_clear got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midreset_nodone got %0d done pulses want 0", extra);
        end
        do_op8(8'h55, 8'h11, 1'b0, cyc, to, bcnt, ovl);
        checks++;
        if (to || sum8 !== 8'h66 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next got timeout=%b sum=%h cout=%b ovf=%b want 0/66/0/0",
                     to, sum8, cout8, ovf8);
        end
        $display("reset_mid_op: next op sum=%h after %0d cycles", sum8, cyc);
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        c1 = 0; c2 = 0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h30; b8 = 8'h10; sub8 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            c1 = i;
            if (done8) break;
        end
        checks++;
        if (!done8 || c1 != 9 || sum8 !== 8'h30) begin
            errors++;
            $display("FAIL b2b_first got done=%b cycles=%0d sum=%h want 1/9/30", done8, c1, sum8);
        end
        $display("b2b first: sum=%h after %0d cycles", sum8, c1);
        start8 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; sub8 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            c2 = i;
            if (done8) break;
        end
        checks++;
        if (!done8 || c2 != 9 || sum8 !== 8'h20 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got done=%b gap=%0d sum=%h cout=%b ovf=%b want 1/9/20/1/0",
                     done8, c2, sum8, cout8, ovf8);
        end
        $display("b2b second: sum=%h %0d cycles after first", sum8, c2);
        @(negedge clk);
    endtask

    task automatic test_random;
        int cyc, bcnt, rs;
        bit to, ovl, rc, rv;
        logic [7:0] ra, rb, rs8;
        logic rsub;
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rsub = 1'($urandom);
            ref_model(8, int'(ra), int'(rb), rsub, rs, rc, rv);
            rs8 = rs[7:0];
            do_op8(ra, rb, rsub, cyc, to, bcnt, ovl);
            checks++;
            if (to || {sum8, cout8, ovf8} !== {rs8, rc, rv}) begin
                errors++;
                $display("FAIL random a=%h b=%h sub=%b got timeout=%b sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         ra, rb, rsub, to, sum8, cout8, ovf8, rs8, rc, rv);
            end else begin
                $display("random: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b",
                         ra, rb, rsub, sum8, cout8, ovf8);
            end
        end
    endtask

    task automatic test_exhaustive4;
        int cyc, rs, bad;
        bit to, rc, rv;
        logic [3:0] rs4;
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 16; ia++) begin
                bad = 0;
                for (int ib = 0; ib < 16; ib++) begin
                    ref_model(4, ia, ib, bit'(s), rs, rc, rv);
                    rs4 = rs[3:0];
                    do_op4(4'(ia), 4'(ib), 1'(s), cyc, to);
                    checks++;
                    if (to || cyc != 5 || {sum4, cout4, ovf4} !== {rs4, rc, rv}) begin
                        errors++;
                        bad++;
                        $display("FAIL exh4 a=%h b=%h sub=%0d got timeout=%b cycles=%0d sum=%h cout=%b ovf=%b want 5/%h/%b/%b",
                                 ia, ib, s, to, cyc, sum4, cout4, ovf4, rs4, rc, rv);
                    end
                end
                $display("exh4: sub=%0d a=%h 16 cases, %0d bad", s, ia, bad);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;

        test_reset();
        test_directed("add_carry",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        test_directed("add_ovf",     8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        test_directed("sub_borrow",  8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
        test_directed("sub_zero",    8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        test_directed("sub_ovf",     8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        test_exhaustive4();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
